// File: rtl/regfile_wb_queue_if.sv
// Writeback queue bus: ALU and long-latency result sources, the register file
// write port, and the decode-stage forwarding lookups.
interface regfile_wb_queue_if;
    // Port A: single-cycle ALU results
    logic        a_valid;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_ready;
    // Port B: long-latency (load/mul) results
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_ready;
    // Register file write port
    logic [4:0]  WAddr_RF;
    logic        WrEn_RF;
    logic [31:0] WD_RF;
    // Forwarding lookups
    logic [4:0]  qaddr1;
    logic [4:0]  qaddr2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        pending;

    // Producers / decode side
    modport master (
        output a_valid, a_waddr, a_wdata,
        input  a_ready,
        output b_valid, b_waddr, b_wdata,
        input  b_ready,
        input  WAddr_RF, WrEn_RF, WD_RF,
        output qaddr1, qaddr2,
        input  hit1, hit2, fwd1, fwd2, pending
    );

    // Writeback queue side
    modport slave (
        input  a_valid, a_waddr, a_wdata,
        output a_ready,
        input  b_valid, b_waddr, b_wdata,
        output b_ready,
        output WAddr_RF, WrEn_RF, WD_RF,
        input  qaddr1, qaddr2,
        output hit1, hit2, fwd1, fwd2, pending
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file write port. Merges ALU
// (port A) and long-latency (port B) results, drains one write per cycle and
// forwards queued-but-unwritten results to decode.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic              clk,
    input logic              reset,
    regfile_wb_queue_if.slave bus
);

    localparam logic [PTR_W:0] CntLast  = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CntLast2 = (PTR_W + 1)'(DEPTH - 2);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wen_q, wen_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             a_ready, b_ready;
    logic             a_push, b_push, pop;
    logic [PTR_W-1:0] b_slot;

    logic [4:0]       look_addr [2];
    logic             look_hit  [2];
    logic [31:0]      look_data [2];

    // Handshake, push/pop decisions and next-state for pointers, count and output stage
    always_comb begin
        // Ready looks only at the current count; A owns the last free slot.
        a_ready = (count_q <= CntLast);
        b_ready = (count_q <= CntLast2) || ((count_q == CntLast) && !bus.a_valid);
        // Writes to x0 complete the handshake but never occupy a slot.
        a_push  = bus.a_valid && a_ready && (bus.a_waddr != 5'd0);
        b_push  = bus.b_valid && b_ready && (bus.b_waddr != 5'd0);
        pop     = (count_q != '0);
        // B lands behind A when both push in the same cycle.
        b_slot  = a_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        wr_ptr_d = wr_ptr_q + PTR_W'(a_push) + PTR_W'(b_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W + 1)'(a_push) + (PTR_W + 1)'(b_push)
                   - (PTR_W + 1)'(pop);

        wen_d   = pop;
        waddr_d = pop ? addr_q[rd_ptr_q] : waddr_q;
        wdata_d = pop ? data_q[rd_ptr_q] : wdata_q;
    end

    // Entry storage; stale entries are ignored through count, so no reset needed
    always_ff @(posedge clk) begin
        if (a_push) begin
            addr_q[wr_ptr_q] <= bus.a_waddr;
            data_q[wr_ptr_q] <= bus.a_wdata;
        end
        if (b_push) begin
            addr_q[b_slot] <= bus.b_waddr;
            data_q[b_slot] <= bus.b_wdata;
        end
    end

    // Queue control and registered write port, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Forwarding search: output stage is oldest, later FIFO entries override earlier
    always_comb begin
        look_addr[0] = bus.qaddr1;
        look_addr[1] = bus.qaddr2;
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
            if (wen_q && (waddr_q == look_addr[p])) begin
                look_hit[p]  = 1'b1;
                look_data[p] = wdata_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (((PTR_W + 1)'(i) < count_q) &&
                    (addr_q[rd_ptr_q + PTR_W'(i)] == look_addr[p])) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = data_q[rd_ptr_q + PTR_W'(i)];
                end
            end
            if (look_addr[p] == 5'd0) begin
                look_hit[p]  = 1'b0;
                look_data[p] = '0;
            end
        end
    end

    // Output wiring
    always_comb begin
        bus.a_ready  = a_ready;
        bus.b_ready  = b_ready;
        bus.WrEn_RF  = wen_q;
        bus.WAddr_RF = waddr_q;
        bus.WD_RF    = wdata_q;
        bus.hit1     = look_hit[0];
        bus.fwd1     = look_data[0];
        bus.hit2     = look_hit[1];
        bus.fwd2     = look_data[1];
        bus.pending  = (count_q != '0) || wen_q;
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and random bench for regfile_wb_queue with a queue-based reference
// model and a shadow register file.
module tb_regfile_wb_queue;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wb_queue_if bus ();

    regfile_wb_queue #(
        .DEPTH(4),
        .PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] rf_m [32];
    logic [31:0] rf_d [32];
    logic        acc_a, acc_b;
    int          tests = 0;
    int          fails = 0;
    int unsigned fdat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] m_look(input logic [4:0] q);
        logic [32:0] r;
        r = '0;
        if (m_wen && (m_addr == q)) r = {1'b1, m_data};
        foreach (mq[i]) if (mq[i].a == q) r = {1'b1, mq[i].d};
        if (q == 5'd0) r = '0;
        return r;
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic tick();
        logic [32:0] l1, l2;
        logic        ea, eb;
        int          n;
        ent_t        ia, ib, e;
        #1;
        n  = mq.size();
        ea = (n <= 3);
        eb = (n <= 2) || ((n == 3) && !bus.a_valid);
        if (!reset) begin
            l1 = m_look(bus.qaddr1);
            l2 = m_look(bus.qaddr2);
            chk("a_ready", {31'b0, bus.a_ready}, {31'b0, ea});
            chk("b_ready", {31'b0, bus.b_ready}, {31'b0, eb});
            chk("hit1", {31'b0, bus.hit1}, {31'b0, l1[32]});
            chk("fwd1", bus.fwd1, l1[31:0]);
            chk("hit2", {31'b0, bus.hit2}, {31'b0, l2[32]});
            chk("fwd2", bus.fwd2, l2[31:0]);
            chk("pending", {31'b0, bus.pending}, {31'b0, (n != 0) || m_wen});
        end
        acc_a = bus.a_valid && ea;
        acc_b = bus.b_valid && eb;
        ia = {bus.a_waddr, bus.a_wdata};
        ib = {bus.b_waddr, bus.b_wdata};
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_wen  = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_wen  = 1'b1;
                m_addr = e.a;
                m_data = e.d;
                rf_m[e.a] = e.d;
            end else begin
                m_wen = 1'b0;
            end
            if (acc_a && (ia.a != 5'd0)) mq.push_back(ia);
            if (acc_b && (ib.a != 5'd0)) mq.push_back(ib);
        end
        chk("wen", {31'b0, bus.WrEn_RF}, {31'b0, m_wen});
        chk("waddr", {27'b0, bus.WAddr_RF}, {27'b0, m_addr});
        chk("wdata", bus.WD_RF, m_data);
        if (bus.WrEn_RF === 1'b1) rf_d[bus.WAddr_RF] = bus.WD_RF;
    endtask

    task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_waddr = a;
        bus.a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_waddr = a;
        bus.b_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_m[i] = '0;
            rf_d[i] = '0;
        end
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        bus.qaddr1 = 5'd0;
        bus.qaddr2 = 5'd0;

        // Reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_wen", {31'b0, bus.WrEn_RF}, 32'd0);
        chk("rst_waddr", {27'b0, bus.WAddr_RF}, 32'd0);
        chk("rst_wd", bus.WD_RF, 32'd0);
        chk("rst_pending", {31'b0, bus.pending}, 32'd0);
        chk("rst_a_ready", {31'b0, bus.a_ready}, 32'd1);
        chk("rst_b_ready", {31'b0, bus.b_ready}, 32'd1);

        // Single A write: visible on the write port two edges after accept
        set_a(1'b1, 5'd5, 32'h11);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        chk("t1_wen_e0", {31'b0, bus.WrEn_RF}, 32'd0);
        tick();
        chk("t1_wen_e1", {31'b0, bus.WrEn_RF}, 32'd1);
        chk("t1_waddr_e1", {27'b0, bus.WAddr_RF}, 32'd5);
        chk("t1_wd_e1", bus.WD_RF, 32'h11);
        tick();
        chk("t1_wen_e2", {31'b0, bus.WrEn_RF}, 32'd0);
        chk("t1_pending_e2", {31'b0, bus.pending}, 32'd0);

        // A and B to the same register in one cycle
        bus.qaddr1 = 5'd3;
        set_a(1'b1, 5'd3, 32'hA);
        set_b(1'b1, 5'd3, 32'hB);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        chk("t2_hit_q", {31'b0, bus.hit1}, 32'd1);
        chk("t2_fwd_q", bus.fwd1, 32'hB);
        tick();
        chk("t2_wd_a", bus.WD_RF, 32'hA);
        chk("t2_fwd_a", bus.fwd1, 32'hB);
        tick();
        chk("t2_wd_b", bus.WD_RF, 32'hB);
        chk("t2_hit_b", {31'b0, bus.hit1}, 32'd1);
        chk("t2_fwd_b", bus.fwd1, 32'hB);
        tick();
        chk("t2_wen_done", {31'b0, bus.WrEn_RF}, 32'd0);
        chk("t2_hit_done", {31'b0, bus.hit1}, 32'd0);

        // Fill: A and B presented every cycle
        fdat = 32'h100;
        set_a(1'b1, 5'd8, fdat);
        set_b(1'b1, 5'd9, fdat + 1);
        fdat = fdat + 2;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (acc_a) begin
                bus.a_waddr = 5'(8 + (fdat % 4));
                bus.a_wdata = fdat;
                fdat++;
            end
            if (acc_b) begin
                bus.b_waddr = 5'(12 + (fdat % 4));
                bus.b_wdata = fdat;
                fdat++;
            end
            if (c == 1) begin
                #1;
                chk("fill_c3_a_ready", {31'b0, bus.a_ready}, 32'd1);
                chk("fill_c3_b_ready", {31'b0, bus.b_ready}, 32'd0);
            end
        end
        bus.a_valid = 1'b0;
        #1;
        chk("fill_c3_b_alone", {31'b0, bus.b_ready}, 32'd1);
        tick();
        bus.b_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("fill_drained", {31'b0, bus.pending}, 32'd0);

        // Write to x0 completes but is dropped
        set_a(1'b1, 5'd0, 32'hDEAD);
        bus.qaddr1 = 5'd0;
        #1;
        chk("x0_a_ready", {31'b0, bus.a_ready}, 32'd1);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("x0_wen", {31'b0, bus.WrEn_RF}, 32'd0);
        end
        chk("x0_hit", {31'b0, bus.hit1}, 32'd0);

        // Reset with entries in flight
        set_a(1'b1, 5'd1, 32'h101);
        set_b(1'b1, 5'd2, 32'h202);
        tick();
        set_a(1'b1, 5'd4, 32'h404);
        set_b(1'b0, 5'd0, 32'd0);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.qaddr1 = 5'd1;
        bus.qaddr2 = 5'd2;
        #1;
        chk("rst2_wen", {31'b0, bus.WrEn_RF}, 32'd0);
        chk("rst2_pending", {31'b0, bus.pending}, 32'd0);
        chk("rst2_hit1", {31'b0, bus.hit1}, 32'd0);
        chk("rst2_hit2", {31'b0, bus.hit2}, 32'd0);
        bus.qaddr1 = 5'd4;
        #1;
        chk("rst2_hit_r4", {31'b0, bus.hit1}, 32'd0);
        set_a(1'b1, 5'd7, 32'h7);
        tick();
        set_a(1'b0, 5'd0, 32'd0);
        tick();
        chk("rst2_wen_r7", {31'b0, bus.WrEn_RF}, 32'd1);
        chk("rst2_waddr_r7", {27'b0, bus.WAddr_RF}, 32'd7);
        chk("rst2_wd_r7", bus.WD_RF, 32'h7);

        // Random traffic; sources hold until accepted
        for (int c = 0; c < 1000; c++) begin
            if (!bus.a_valid || acc_a) begin
                bus.a_valid = 1'($urandom_range(0, 1));
                bus.a_waddr = 5'($urandom_range(0, 7));
                bus.a_wdata = $urandom;
            end
            if (!bus.b_valid || acc_b) begin
                bus.b_valid = 1'($urandom_range(0, 1));
                bus.b_waddr = 5'($urandom_range(0, 7));
                bus.b_wdata = $urandom;
            end
            bus.qaddr1 = 5'($urandom_range(0, 7));
            bus.qaddr2 = 5'($urandom_range(0, 7));
            acc_a = 1'b0;
            acc_b = 1'b0;
            tick();
        end
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 8; c++) tick();
        chk("rand_pending", {31'b0, bus.pending}, 32'd0);
        for (int i = 1; i < 32; i++) chk($sformatf("rf_r%0d", i), rf_d[i], rf_m[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
